// File: rtl/envelope_generator_pkg.sv
// envelope_generator_pkg: envelope state encoding and unity-gain constant shared with the VCA multiplier.
package envelope_generator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    function automatic int unsigned unity_gain(input int unsigned bitsize);
        return 32'd1 << (bitsize - 2);
    endfunction

endpackage

// File: rtl/env_step_unit.sv
// env_step_unit: saturating add/subtract toward a target level, flagging when the target is reached.
module env_step_unit #(
    parameter int AW    = 23,
    parameter int STEPW = 16
) (
    input  logic [AW-1:0]    acc,
    input  logic [STEPW-1:0] step,
    input  logic [AW-1:0]    target,
    input  logic             sub,
    output logic [AW-1:0]    res,
    output logic             hit
);

    logic [AW:0] step_x;
    logic [AW:0] sum;
    logic [AW:0] lim;

    // One guard bit keeps both the sum and the target+step limit from wrapping.
    always_comb begin
        step_x = (AW+1)'(step);
        sum    = {1'b0, acc} + step_x;
        lim    = {1'b0, target} + step_x;
        hit    = sub ? ({1'b0, acc} <= lim) : (sum >= {1'b0, target});
        res    = hit ? target : sub ? acc - step_x[AW-1:0] : sum[AW-1:0];
    end

endmodule

// File: rtl/envelope_generator.sv
// envelope_generator: per-sample ADSR envelope producing a Q2.(BITSIZE-2) gain word for the VCA multiplier.
module envelope_generator
    import envelope_generator_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 8,
    parameter int STEPW   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_en,
    input  logic               gate,
    input  logic [STEPW-1:0]   attack_step,
    input  logic [STEPW-1:0]   decay_step,
    input  logic [BITSIZE-2:0] sustain_level,
    input  logic [STEPW-1:0]   release_step,
    output logic [BITSIZE-1:0] env,
    output logic               env_valid,
    output logic [2:0]         stage,
    output logic               active
);

    localparam int AW = BITSIZE - 1 + FRAC;
    localparam logic [BITSIZE-2:0] UNITY = (BITSIZE-1)'(unity_gain(BITSIZE));
    localparam logic [AW-1:0] PEAK = {UNITY, {FRAC{1'b0}}};

    env_state_e         state_q, state_d, cur;
    logic [AW-1:0]      acc_q, acc_d;
    logic               gate_prev_q, gate_prev_d;
    logic               env_valid_q, env_valid_d;
    logic               rise, fall, hit;
    logic [BITSIZE-2:0] sus_lvl;
    logic [AW-1:0]      sus, target, step_res;
    logic [STEPW-1:0]   step;

    // Gate edges override the current state before the per-state step is applied.
    always_comb begin
        rise    = gate & ~gate_prev_q;
        fall    = ~gate & gate_prev_q;
        sus_lvl = (sustain_level > UNITY) ? UNITY : sustain_level;
        sus     = {sus_lvl, {FRAC{1'b0}}};
        cur     = rise ? ST_ATTACK
                : (fall && state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN}) ? ST_RELEASE
                : state_q;
        step    = (cur == ST_ATTACK) ? attack_step : (cur == ST_DECAY) ? decay_step : release_step;
        target  = (cur == ST_ATTACK) ? PEAK : (cur == ST_DECAY) ? sus : '0;
    end

    env_step_unit #(.AW(AW), .STEPW(STEPW)) u_step (
        .acc    (acc_q),
        .step   (step),
        .target (target),
        .sub    (cur != ST_ATTACK),
        .res    (step_res),
        .hit    (hit)
    );

    always_comb begin
        acc_d       = acc_q;
        state_d     = state_q;
        gate_prev_d = gate_prev_q;
        env_valid_d = sample_en;
        if (sample_en) begin
            gate_prev_d = gate;
            case (cur)
                ST_ATTACK: begin
                    acc_d   = step_res;
                    state_d = hit ? ST_DECAY : ST_ATTACK;
                end
                ST_DECAY: begin
                    acc_d   = step_res;
                    state_d = hit ? ST_SUSTAIN : ST_DECAY;
                end
                ST_SUSTAIN: begin
                    acc_d   = sus;
                    state_d = ST_SUSTAIN;
                end
                ST_RELEASE: begin
                    acc_d   = step_res;
                    state_d = hit ? ST_IDLE : ST_RELEASE;
                end
                default: begin
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            state_q     <= ST_IDLE;
            gate_prev_q <= 1'b0;
            env_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            state_q     <= state_d;
            gate_prev_q <= gate_prev_d;
            env_valid_q <= env_valid_d;
        end
    end

    assign env       = {1'b0, acc_q[AW-1:FRAC]};
    assign env_valid = env_valid_q;
    assign stage     = state_q;
    assign active    = state_q != ST_IDLE;

endmodule

// File: tb/tb_envelope_generator.sv
// tb_envelope_generator: randomized and directed checks of the ADSR envelope against an arithmetic model.
module tb_envelope_generator;

    localparam longint PEAK = 64'd4194304;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic        gate = 1'b0;
    logic [15:0] attack_step = '0;
    logic [15:0] decay_step = '0;
    logic [14:0] sustain_level = '0;
    logic [15:0] release_step = '0;
    logic [15:0] env;
    logic        env_valid;
    logic [2:0]  stage;
    logic        active;

    int n_chk = 0;
    int n_fail = 0;

    longint m_lv = 0;
    int     m_st = 0;
    bit     m_gp = 0;

    wire [20:0] obs = {env, stage, active, env_valid};

    envelope_generator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_en     (sample_en),
        .gate          (gate),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .env           (env),
        .env_valid     (env_valid),
        .stage         (stage),
        .active        (active)
    );

    always #5 clk = ~clk;

    // Level in accumulator units, state as 0..4 (IDLE..RELEASE).
    function automatic void model_tick();
        longint sus;
        bit rise, fall;
        sus  = ((sustain_level > 15'd16384) ? 64'd16384 : longint'(sustain_level)) << 8;
        rise = gate && !m_gp;
        fall = !gate && m_gp;
        if (rise) m_st = 1;
        else if (fall && m_st >= 1 && m_st <= 3) m_st = 4;
        case (m_st)
            1: if (m_lv + attack_step >= PEAK) begin m_lv = PEAK; m_st = 2; end
               else m_lv = m_lv + attack_step;
            2: if (m_lv <= sus + decay_step) begin m_lv = sus; m_st = 3; end
               else m_lv = m_lv - decay_step;
            3: m_lv = sus;
            4: if (m_lv <= release_step) begin m_lv = 0; m_st = 0; end
               else m_lv = m_lv - release_step;
            default: m_lv = 0;
        endcase
        m_gp = gate;
    endfunction

    function automatic logic [20:0] exp_vec(input bit v);
        return {16'(m_lv >> 8), 3'(m_st), m_st != 0, v};
    endfunction

    task automatic tick();
        @(negedge clk) sample_en = 1'b1;
        @(negedge clk) sample_en = 1'b0;
        model_tick();
    endtask

    task automatic gap();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_held: {env,stage,active,valid}=%h expected %h", obs, 21'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (obs !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_released: {env,stage,active,valid}=%h expected %h", obs, 21'd0);
        end
    endtask

    task automatic test_reset_mid_attack();
        gate = 1'b1;
        attack_step = 16'd48000;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_chk++;
            if (obs !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL pre_reset_attack tick %0d: got %h expected %h", k, obs, exp_vec(1));
            end
            gap();
        end
        n_chk++;
        if (env !== 16'd3000 || stage !== 3'd1) begin
            n_fail++;
            $display("FAIL pre_reset_level: env=%0d stage=%0d expected env=3000 stage=1", env, stage);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (env !== 16'd0 || stage !== 3'd0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: env=%0d stage=%0d active=%0b expected 0 0 0", env, stage, active);
        end
        gate = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        m_lv = 0;
        m_st = 0;
        m_gp = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_chk++;
            if (obs !== exp_vec(1) || stage !== 3'd0) begin
                n_fail++;
                $display("FAIL post_reset_idle tick %0d: got %h expected %h", k, obs, exp_vec(1));
            end
            gap();
        end
    endtask

    task automatic test_attack();
        gate = 1'b1;
        attack_step = 16'd16384;
        decay_step = 16'd16384;
        sustain_level = 15'd8192;
        release_step = 16'd25600;
        for (int k = 1; k <= 256; k++) begin
            tick();
            n_chk++;
            if (obs !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL attack tick %0d: got %h expected %h", k, obs, exp_vec(1));
            end
            n_chk++;
            if (env !== 16'(64 * k)) begin
                n_fail++;
                $display("FAIL attack_ramp tick %0d: env=%0d expected %0d", k, env, 64 * k);
            end
            @(negedge clk);
            n_chk++;
            if (env_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL valid_pulse tick %0d: env_valid=%0b expected 0", k, env_valid);
            end
            @(negedge clk);
        end
        n_chk++;
        if (env !== 16'd16384 || stage !== 3'd2) begin
            n_fail++;
            $display("FAIL attack_peak: env=%0d stage=%0d expected 16384 2", env, stage);
        end
    endtask

    task automatic test_decay();
        for (int k = 1; k <= 128; k++) begin
            tick();
            n_chk++;
            if (obs !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL decay tick %0d: got %h expected %h", k, obs, exp_vec(1));
            end
            gap();
        end
        n_chk++;
        if (env !== 16'd8192 || stage !== 3'd3) begin
            n_fail++;
            $display("FAIL decay_to_sustain: env=%0d stage=%0d expected 8192 3", env, stage);
        end
        sustain_level = 15'd4000;
        tick();
        n_chk++;
        if (env !== 16'd4000 || stage !== 3'd3 || obs !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL sustain_track: env=%0d stage=%0d expected 4000 3", env, stage);
        end
        gap();
    endtask

    task automatic test_release();
        gate = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_chk++;
            if (obs !== exp_vec(1) || env !== 16'(4000 - 100 * k)) begin
                n_fail++;
                $display("FAIL release tick %0d: env=%0d stage=%0d expected env=%0d", k, env, stage, 4000 - 100 * k);
            end
            gap();
        end
        n_chk++;
        if (env !== 16'd0 || stage !== 3'd0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL release_end: env=%0d stage=%0d active=%0b expected 0 0 0", env, stage, active);
        end
    endtask

    task automatic test_retrigger();
        gate = 1'b1;
        attack_step = 16'd65535;
        decay_step = 16'd65535;
        sustain_level = 15'd2000;
        for (int k = 0; k < 200 && m_st != 3; k++) begin
            tick();
            n_chk++;
            if (obs !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL retrig_setup tick %0d: got %h expected %h", k, obs, exp_vec(1));
            end
            gap();
        end
        gate = 1'b0;
        release_step = 16'd0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_chk++;
            if (env !== 16'd2000 || stage !== 3'd4 || obs !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL release_zero_step tick %0d: env=%0d stage=%0d expected 2000 4", k, env, stage);
            end
            gap();
        end
        gate = 1'b1;
        attack_step = 16'd16384;
        tick();
        n_chk++;
        if (env !== 16'd2064 || stage !== 3'd1 || obs !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL retrigger: env=%0d stage=%0d expected 2064 1", env, stage);
        end
        gap();
    endtask

    task automatic test_clamp();
        gate = 1'b0;
        release_step = 16'd65535;
        for (int k = 0; k < 300 && m_st != 0; k++) begin
            tick();
            n_chk++;
            if (obs !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL clamp_drain tick %0d: got %h expected %h", k, obs, exp_vec(1));
            end
            gap();
        end
        sustain_level = 15'd30000;
        gate = 1'b1;
        attack_step = 16'd65535;
        decay_step = 16'd1000;
        for (int k = 0; k < 300 && m_st != 2; k++) begin
            tick();
            n_chk++;
            if (obs !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL clamp_attack tick %0d: got %h expected %h", k, obs, exp_vec(1));
            end
            gap();
        end
        tick();
        n_chk++;
        if (env !== 16'd16384 || stage !== 3'd3) begin
            n_fail++;
            $display("FAIL sustain_clamp: env=%0d stage=%0d expected 16384 3", env, stage);
        end
        gap();
    endtask

    task automatic test_zero_attack();
        gate = 1'b0;
        release_step = 16'd25600;
        for (int k = 1; k <= 5; k++) begin
            tick();
            gap();
        end
        n_chk++;
        if (env !== 16'd15884 || stage !== 3'd4) begin
            n_fail++;
            $display("FAIL zero_attack_setup: env=%0d stage=%0d expected 15884 4", env, stage);
        end
        gate = 1'b1;
        attack_step = 16'd0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_chk++;
            if (env !== 16'd15884 || stage !== 3'd1 || obs !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL zero_attack_hold tick %0d: env=%0d stage=%0d expected 15884 1", k, env, stage);
            end
            gap();
        end
        gate = 1'b0;
        tick();
        n_chk++;
        if (env !== 16'd15784 || stage !== 3'd4) begin
            n_fail++;
            $display("FAIL zero_attack_release: env=%0d stage=%0d expected 15784 4", env, stage);
        end
        gap();
    endtask

    task automatic test_back_to_back();
        gate = 1'b1;
        attack_step = 16'd40000;
        decay_step = 16'd30000;
        sustain_level = 15'd9000;
        release_step = 16'd20000;
        for (int r = 0; r < 20; r++) begin
            @(negedge clk) sample_en = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                model_tick();
                n_chk++;
                if (obs !== exp_vec(1)) begin
                    n_fail++;
                    $display("FAIL back_to_back run %0d beat %0d: got %h expected %h", r, i, obs, exp_vec(1));
                end
                if (i == 3) sample_en = 1'b0;
                else if ($urandom_range(0, 3) == 0) gate = ~gate;
            end
        end
        gap();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) gate = ~gate;
            if ($urandom_range(0, 15) == 0) begin
                attack_step = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
                decay_step = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
                release_step = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
                sustain_level = 15'($urandom);
            end
            tick();
            n_chk++;
            if (obs !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL random tick %0d: got %h expected %h", k, obs, exp_vec(1));
            end
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                n_chk++;
                if (obs !== exp_vec(0)) begin
                    n_fail++;
                    $display("FAIL random_hold tick %0d: got %h expected %h", k, obs, exp_vec(0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_attack();
        test_attack();
        test_decay();
        test_release();
        test_retrigger();
        test_clamp();
        test_zero_attack();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/envelope_generator.md
Name: envelope_generator

Overview:
- ADSR envelope generator that produces the gain word driving the `in2` (gain) operand of the downstream `multiplier` VCA stage; audio drives `in1`.
- Advances once per audio sample on a one-cycle sample strobe. Output is a non-negative signed gain in the multiplier's Q2.(BITSIZE-2) format: unity = 2^(BITSIZE-2), i.e. 16384 at 16 bits.
- Internal accumulator carries FRAC extra fractional bits so slow rates remain resolvable.

Parameters:
- BITSIZE, 16, width of `env` and of the multiplier data path.
- FRAC, 8, fractional bits in the level accumulator below the `env` LSB.
- STEPW, 16, width of the attack/decay/release step inputs, in accumulator LSBs.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_en  in  1  one-cycle strobe per audio sample; all envelope motion happens only on these cycles.
- gate  in  1  note on (1) / off (0); sampled only on sample_en cycles.
- attack_step  in  STEPW  unsigned accumulator increment per sample in ATTACK.
- decay_step  in  STEPW  unsigned decrement per sample in DECAY.
- sustain_level  in  BITSIZE-1  unsigned sustain gain in env units; values above 2^(BITSIZE-2) clamp to unity.
- release_step  in  STEPW  unsigned decrement per sample in RELEASE.
- env  out  BITSIZE  signed gain, range 0..2^(BITSIZE-2).
- env_valid  out  1  one-cycle pulse; env was updated this cycle.
- stage  out  3  current state encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- active  out  1  1 whenever stage != IDLE.

Behaviour:
- Accumulator `acc`: unsigned, BITSIZE-1+FRAC bits. PEAK = 2^(BITSIZE-2+FRAC). SUS = min(sustain_level, 2^(BITSIZE-2)) << FRAC.
- `env` = acc >> FRAC, zero-extended to BITSIZE. Its MSB (sign) is always 0.
- Reset (async, rst_n=0): acc=0, state=IDLE, gate_prev=0, env=0, env_valid=0, stage=0, active=0. Deasserting mid-envelope restarts from IDLE/0; no partial state survives.
- Cycles without sample_en: acc, state and gate_prev hold; env_valid=0.
- On a sample_en cycle, with rise = gate & ~gate_prev and fall = ~gate & gate_prev, the first matching rule applies:
  - rise, from any state → ATTACK. acc is not reset (legato/retrigger from current level); the attack step also applies this same tick.
  - fall, from ATTACK/DECAY/SUSTAIN → RELEASE; the release step applies this tick.
  - ATTACK: if acc + attack_step >= PEAK, then acc=PEAK and go to DECAY; else acc += attack_step.
  - DECAY: if acc <= SUS + decay_step, then acc=SUS and go to SUSTAIN; else acc -= decay_step.
  - SUSTAIN: acc = SUS, so sustain_level changes are tracked immediately.
  - RELEASE: if acc <= release_step, then acc=0 and go to IDLE; else acc -= release_step.
  - IDLE: acc=0.
  - gate_prev <= gate.
- Zero step: level holds and state remains (ATTACK with step 0 stalls until gate falls). Exception: DECAY with SUS == acc goes to SUSTAIN on that tick.
- Arithmetic uses one guard bit, so there is no wrap-around. acc never exceeds PEAK and never goes below 0.
- Latency: env, stage, active and env_valid are registered and reflect the tick one clock after the sample_en cycle. Downstream multiplier adds 2 cycles, so gain reaches audio 3 clocks after sample_en.
- Gate pulses shorter than a sample period between strobes are ignored by design.
- sample_en asserted on consecutive cycles is legal; each assertion is one tick.

Decomposition:
- Shared audio package holds:
  - the state enumeration (IDLE..RELEASE, 3-bit);
  - a unity-gain constant function, 2^(BITSIZE-2), also used by the multiplier tests.
- A single sub-module `env_step_unit` is natural: a combinational saturating add/subtract with a reached-target flag, used by ATTACK, DECAY and RELEASE. The FSM and registers stay in `envelope_generator`.

Test Plan (BITSIZE=16, FRAC=8, PEAK=4194304, sample_en every 4 clocks):
- Reset mid-ATTACK (env=3000): pull rst_n low asynchronously between clock edges → env=0, stage=0, active=0 immediately; after release, stays IDLE until the next gate rise.
- gate rise, attack_step=16384 → env rises 64 per tick, reaches 16384 on tick 256, stage goes 1→2 the same tick; env_valid pulses once per tick, 1 clock after sample_en.
- Continue with decay_step=16384, sustain_level=8192 → env drops 64 per tick, hits exactly 8192 after 128 ticks, stage=3. Then change sustain_level to 4000 → env=4000 on the next tick.
- From SUSTAIN at 4000, gate falls with release_step=25600 (100 env units/tick) → ticks 3900, 3800, …, 100, then 0 with stage=0, active=0, after 40 ticks.
- Retrigger in RELEASE at env=2000 with attack_step=16384 → stage=1 and env=2064 on that tick, with no dip to 0.
- Clamp and zero-step edges:
  - sustain_level=30000 → SUS=16384, so DECAY→SUSTAIN happens on the first decay tick.
  - attack_step=0 → env holds at its starting value in ATTACK until gate falls, then RELEASE.
